// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port clearable RAM: read-during-write
// mode codes and the clear sequencer state encoding.
package ram_pkg;

    // Same-port read-during-write modes (values of rdw_new_g)
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Clear sequencer states
    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage : ram_pkg

// File: rtl/ram_dp_clr_if.sv
// Bus bundle for ram_dp_clr: two read/write ports plus the clear request
// and busy status. master = requesting agent, slave = the RAM.
interface ram_dp_clr_if #(
    parameter int addr_width_g = 11,
    parameter int data_width_g = 8
);
    logic [addr_width_g-1:0] a_addr;
    logic [data_width_g-1:0] a_data;
    logic                    a_wren;
    logic [data_width_g-1:0] a_q;
    logic [addr_width_g-1:0] b_addr;
    logic [data_width_g-1:0] b_data;
    logic                    b_wren;
    logic [data_width_g-1:0] b_q;
    logic                    clr_req;
    logic                    busy;

    modport master (
        output a_addr, a_data, a_wren, b_addr, b_data, b_wren, clr_req,
        input  a_q, b_q, busy
    );

    modport slave (
        input  a_addr, a_data, a_wren, b_addr, b_data, b_wren, clr_req,
        output a_q, b_q, busy
    );
endinterface : ram_dp_clr_if

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps every address once, writing a constant fill word.
// Comes out of reset already sweeping, so busy is high from reset and the
// array is filled in the 2**addr_width_g cycles following reset release.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int          addr_width_g = 11,
    parameter int          data_width_g = 8,
    parameter int unsigned clr_value_g  = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    i_clr_req,
    output logic                    o_busy,
    output logic                    o_we,
    output logic [addr_width_g-1:0] o_addr,
    output logic [data_width_g-1:0] o_data
);

    localparam logic [addr_width_g-1:0] CNT_LAST = {addr_width_g{1'b1}};

    clr_state_t              r_state;
    logic [addr_width_g-1:0] r_cnt;
    logic                    r_busy;

    // Sweep FSM: a request restarts at address 0, the last address ends the sweep
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLR_RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                CLR_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= CLR_RUN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    if (i_clr_req) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= CLR_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + addr_width_g'(1);
                    end
                end
                default: begin
                    r_state <= CLR_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_we   = r_busy;
    assign o_addr = r_cnt;
    assign o_data = data_width_g'(clr_value_g);

endmodule : ram_clr_seq

// File: rtl/ram_dp_clr.sv
// True dual-port synchronous RAM with selectable same-port read-during-write,
// optional output register stage and an optional hardware clear sweep.
// Build option: define RAM_DP_CLR_SEQ_EN to compile in the clear sequencer;
// without it busy is tied low, clr_req is ignored and power-up contents are
// undefined.
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int          addr_width_g = 11,
    parameter int          data_width_g = 8,
    parameter int          rdw_new_g    = 0,
    parameter int          out_reg_g    = 0,
    parameter int unsigned clr_value_g  = 0
) (
    input  logic         clock,
    input  logic         reset_n,
    ram_dp_clr_if.slave  bus
);

    localparam int DEPTH = 2 ** addr_width_g;

    logic [data_width_g-1:0] r_mem [DEPTH];

    logic                    w_busy;
    logic                    w_seq_we;
    logic [addr_width_g-1:0] w_seq_addr;
    logic [data_width_g-1:0] w_seq_data;

`ifdef RAM_DP_CLR_SEQ_EN
    ram_clr_seq #(
        .addr_width_g (addr_width_g),
        .data_width_g (data_width_g),
        .clr_value_g  (clr_value_g)
    ) u_clr_seq (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clr_req (bus.clr_req),
        .o_busy    (w_busy),
        .o_we      (w_seq_we),
        .o_addr    (w_seq_addr),
        .o_data    (w_seq_data)
    );
`else
    localparam logic [data_width_g-1:0] unused_clr_word = data_width_g'(clr_value_g);
    logic w_unused_clr_req;
    assign w_unused_clr_req = bus.clr_req;
    assign w_busy     = 1'b0;
    assign w_seq_we   = 1'b0;
    assign w_seq_addr = '0;
    assign w_seq_data = unused_clr_word;
`endif

    logic                    w_a_we;
    logic                    w_b_we;
    logic                    w_p0_we;
    logic [addr_width_g-1:0] w_p0_addr;
    logic [data_width_g-1:0] w_p0_data;

    // Write arbitration: sweep owns write port 0, A beats B on an address collision
    always_comb begin
        w_a_we = bus.a_wren & ~w_busy;
        w_b_we = bus.b_wren & ~w_busy & ~(bus.a_wren & (bus.a_addr == bus.b_addr));
        if (w_seq_we) begin
            w_p0_we   = 1'b1;
            w_p0_addr = w_seq_addr;
            w_p0_data = w_seq_data;
        end else begin
            w_p0_we   = w_a_we;
            w_p0_addr = bus.a_addr;
            w_p0_data = bus.a_data;
        end
    end

    // Array writes; storage is deliberately left out of reset
    always_ff @(posedge clock) begin
        if (w_p0_we) begin
            r_mem[w_p0_addr] <= w_p0_data;
        end
        if (w_b_we) begin
            r_mem[bus.b_addr] <= bus.b_data;
        end
    end

    logic [data_width_g-1:0] w_a_rd;
    logic [data_width_g-1:0] w_b_rd;

    // Read word selection: cross-port always old, same-port per rdw_new_g
    always_comb begin
        w_a_rd = r_mem[bus.a_addr];
        w_b_rd = r_mem[bus.b_addr];
        case (rdw_new_g)
            RDW_OLD: begin
                w_a_rd = r_mem[bus.a_addr];
                w_b_rd = r_mem[bus.b_addr];
            end
            RDW_NEW: begin
                if (w_a_we) begin
                    w_a_rd = bus.a_data;
                end else begin
                    w_a_rd = r_mem[bus.a_addr];
                end
                if (w_b_we) begin
                    w_b_rd = bus.b_data;
                end else begin
                    w_b_rd = r_mem[bus.b_addr];
                end
            end
            default: begin
                w_a_rd = r_mem[bus.a_addr];
                w_b_rd = r_mem[bus.b_addr];
            end
        endcase
    end

    logic [data_width_g-1:0] r_a_rd;
    logic [data_width_g-1:0] r_b_rd;

    // First read register stage, present in every configuration
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_rd <= '0;
            r_b_rd <= '0;
        end else begin
            r_a_rd <= w_a_rd;
            r_b_rd <= w_b_rd;
        end
    end

    generate
        if (out_reg_g != 0) begin : g_out_reg
            logic [data_width_g-1:0] r_a_q;
            logic [data_width_g-1:0] r_b_q;

            // Optional second output stage for timing relief
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_a_q <= '0;
                    r_b_q <= '0;
                end else begin
                    r_a_q <= r_a_rd;
                    r_b_q <= r_b_rd;
                end
            end

            assign bus.a_q = r_a_q;
            assign bus.b_q = r_b_q;
        end else begin : g_no_out_reg
            assign bus.a_q = r_a_rd;
            assign bus.b_q = r_b_rd;
        end
    endgenerate

    assign bus.busy = w_busy;

endmodule : ram_dp_clr

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr. Two instances share the stimulus:
// u0 = old-data read-during-write, no output register;
// u1 = new-data read-during-write, with output register.
// Clear-sequence scenarios run only when RAM_DP_CLR_SEQ_EN is defined.
module tb_ram_dp_clr;

`ifdef RAM_DP_CLR_SEQ_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif
    localparam logic [7:0] CLR = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] a_addr = 4'd0, b_addr = 4'd0;
    logic [7:0] a_data = 8'd0, b_data = 8'd0;
    logic       a_wren = 1'b0, b_wren = 1'b0, clr_req = 1'b0;

    ram_dp_clr_if #(.addr_width_g(4), .data_width_g(8)) bus0 ();
    ram_dp_clr_if #(.addr_width_g(4), .data_width_g(8)) bus1 ();

    assign bus0.a_addr = a_addr;  assign bus1.a_addr = a_addr;
    assign bus0.a_data = a_data;  assign bus1.a_data = a_data;
    assign bus0.a_wren = a_wren;  assign bus1.a_wren = a_wren;
    assign bus0.b_addr = b_addr;  assign bus1.b_addr = b_addr;
    assign bus0.b_data = b_data;  assign bus1.b_data = b_data;
    assign bus0.b_wren = b_wren;  assign bus1.b_wren = b_wren;
    assign bus0.clr_req = clr_req; assign bus1.clr_req = clr_req;

    ram_dp_clr #(.addr_width_g(4), .data_width_g(8), .rdw_new_g(0),
                 .out_reg_g(0), .clr_value_g(32'hA5))
        u0 (.clock(clk), .reset_n(rst_n), .bus(bus0));
    ram_dp_clr #(.addr_width_g(4), .data_width_g(8), .rdw_new_g(1),
                 .out_reg_g(1), .clr_value_g(32'hA5))
        u1 (.clock(clk), .reset_n(rst_n), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural reference: memory contents, sweep position, expected outputs
    logic [7:0] m_mem [16];
    bit         m_val [16];
    bit         m_busy;
    int         m_cnt;
    logic [7:0] e0_a, e0_b, e1_a, e1_b, p1_a, p1_b;
    bit         k0_a, k0_b, k1_a, k1_b, pk1_a, pk1_b;

    // One clock of the reference model; returns #1 after the rising edge
    task automatic step();
        logic [7:0] rd0_a, rd0_b, rd1_a, rd1_b;
        bit wa, wb, kr_a, kr_b;
        wa = a_wren && !m_busy;
        wb = b_wren && !m_busy && !(a_wren && a_addr == b_addr);
        rd0_a = m_mem[a_addr];  kr_a = m_val[a_addr] && !m_busy;
        rd0_b = m_mem[b_addr];  kr_b = m_val[b_addr] && !m_busy;
        rd1_a = wa ? a_data : rd0_a;
        rd1_b = wb ? b_data : rd0_b;
        @(posedge clk);
        e0_a = rd0_a; k0_a = kr_a;
        e0_b = rd0_b; k0_b = kr_b;
        e1_a = p1_a;  k1_a = pk1_a;
        e1_b = p1_b;  k1_b = pk1_b;
        p1_a = rd1_a; pk1_a = wa || kr_a;
        p1_b = rd1_b; pk1_b = wb || kr_b;
        if (m_busy) begin
            m_mem[m_cnt] = CLR;
            m_val[m_cnt] = 1'b1;
            if (clr_req) m_cnt = 0;
            else if (m_cnt == 15) begin m_busy = 1'b0; m_cnt = 0; end
            else m_cnt++;
        end else begin
            if (wb) begin m_mem[b_addr] = b_data; m_val[b_addr] = 1'b1; end
            if (wa) begin m_mem[a_addr] = a_data; m_val[a_addr] = 1'b1; end
            if (clr_req && SEQ) begin m_busy = 1'b1; m_cnt = 0; end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus0.a_q !== 8'h00) begin n_fail++; $display("FAIL reset u0.a_q: got %h want 00", bus0.a_q); end
        n_tests++; if (bus0.b_q !== 8'h00) begin n_fail++; $display("FAIL reset u0.b_q: got %h want 00", bus0.b_q); end
        n_tests++; if (bus1.a_q !== 8'h00) begin n_fail++; $display("FAIL reset u1.a_q: got %h want 00", bus1.a_q); end
        n_tests++; if (bus1.b_q !== 8'h00) begin n_fail++; $display("FAIL reset u1.b_q: got %h want 00", bus1.b_q); end
        n_tests++; if (bus0.busy !== SEQ) begin n_fail++; $display("FAIL reset busy: got %b want %b", bus0.busy, SEQ); end
        m_busy = SEQ; m_cnt = 0;
        e0_a = 8'h00; e0_b = 8'h00; e1_a = 8'h00; e1_b = 8'h00; p1_a = 8'h00; p1_b = 8'h00;
        k0_a = 1'b1; k0_b = 1'b1; k1_a = 1'b1; k1_b = 1'b1; pk1_a = 1'b1; pk1_b = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clear_sweep();
        int n_busy;
        n_busy = (bus0.busy === 1'b1) ? 1 : 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus0.busy === 1'b1 && bus1.busy === 1'b1) n_busy++;
            else break;
        end
        n_tests++; if (n_busy != 16) begin n_fail++; $display("FAIL sweep_len: got %0d busy cycles want 16", n_busy); end
        for (int i = 0; i < 17; i++) begin
            a_addr = 4'(i); b_addr = 4'(15 - i);
            step();
            if (i > 0) begin
                n_tests++; if (bus0.a_q !== CLR) begin n_fail++; $display("FAIL sweep_rd_a[%0d]: got %h want a5", i - 1, bus0.a_q); end
                n_tests++; if (bus0.b_q !== CLR) begin n_fail++; $display("FAIL sweep_rd_b[%0d]: got %h want a5", 16 - i, bus0.b_q); end
            end
        end
    endtask

    task automatic test_first_write();
        logic [7:0] d;
        d = 8'($urandom);
        a_addr = 4'd5; a_data = d; a_wren = 1'b1;
        n_tests++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL nosec_busy: got %b want 0", bus0.busy); end
        step();
        a_wren = 1'b0;
        step();
        n_tests++; if (bus0.a_q !== d) begin n_fail++; $display("FAIL first_write: got %h want %h", bus0.a_q, d); end
    endtask

    task automatic test_rdw();
        a_addr = 4'd3; a_data = 8'h11; a_wren = 1'b1; step();
        a_data = 8'h22; step();
        n_tests++; if (bus0.a_q !== 8'h11) begin n_fail++; $display("FAIL rdw_old: got %h want 11", bus0.a_q); end
        a_wren = 1'b0; step();
        n_tests++; if (bus1.a_q !== 8'h22) begin n_fail++; $display("FAIL rdw_new: got %h want 22", bus1.a_q); end
    endtask

    task automatic test_collision();
        a_addr = 4'd7; a_data = 8'h5A; a_wren = 1'b1; b_addr = 4'd0; b_wren = 1'b0; step();
        b_addr = 4'd7; a_data = 8'h3C; b_data = 8'hC3; b_wren = 1'b1; step();
        n_tests++; if (bus0.b_q !== 8'h5A) begin n_fail++; $display("FAIL coll_cross_old: got %h want 5a", bus0.b_q); end
        a_wren = 1'b0; b_wren = 1'b0; step();
        n_tests++; if (bus0.a_q !== 8'h3C) begin n_fail++; $display("FAIL coll_a_wins: got %h want 3c", bus0.a_q); end
        n_tests++; if (bus1.b_q !== 8'h5A) begin n_fail++; $display("FAIL coll_b_dropped: got %h want 5a", bus1.b_q); end
        b_data = 8'h77; b_wren = 1'b1; step();
        n_tests++; if (bus0.a_q !== 8'h3C) begin n_fail++; $display("FAIL cross_rd_old: got %h want 3c", bus0.a_q); end
        b_wren = 1'b0; step();
        n_tests++; if (bus0.a_q !== 8'h77) begin n_fail++; $display("FAIL cross_wr_b: got %h want 77", bus0.a_q); end
    endtask

    task automatic test_out_reg();
        logic [7:0] v1, v2;
        v1 = 8'($urandom); v2 = ~v1;
        a_wren = 1'b1; a_addr = 4'd1; a_data = v1; step();
        a_addr = 4'd2; a_data = v2; step();
        a_wren = 1'b0; a_addr = 4'd1; step();
        a_addr = 4'd2; step();
        n_tests++; if (bus1.a_q !== v1) begin n_fail++; $display("FAIL outreg_lat2: got %h want %h", bus1.a_q, v1); end
        n_tests++; if (bus0.a_q !== v2) begin n_fail++; $display("FAIL noreg_lat1: got %h want %h", bus0.a_q, v2); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            a_addr = 4'($urandom_range(0, 15)); b_addr = 4'($urandom_range(0, 15));
            a_data = 8'($urandom); b_data = 8'($urandom);
            a_wren = 1'($urandom); b_wren = 1'($urandom);
            step();
            if (k0_a) begin n_tests++; if (bus0.a_q !== e0_a) begin n_fail++; $display("FAIL rnd u0.a_q c%0d: got %h want %h", c, bus0.a_q, e0_a); end end
            if (k0_b) begin n_tests++; if (bus0.b_q !== e0_b) begin n_fail++; $display("FAIL rnd u0.b_q c%0d: got %h want %h", c, bus0.b_q, e0_b); end end
            if (k1_a) begin n_tests++; if (bus1.a_q !== e1_a) begin n_fail++; $display("FAIL rnd u1.a_q c%0d: got %h want %h", c, bus1.a_q, e1_a); end end
            if (k1_b) begin n_tests++; if (bus1.b_q !== e1_b) begin n_fail++; $display("FAIL rnd u1.b_q c%0d: got %h want %h", c, bus1.b_q, e1_b); end end
            n_tests++; if (bus0.busy !== m_busy) begin n_fail++; $display("FAIL rnd busy c%0d: got %b want %b", c, bus0.busy, m_busy); end
        end
        a_wren = 1'b0; b_wren = 1'b0;
    endtask

    task automatic test_clear_req();
        int n_busy;
        clr_req = 1'b1; a_wren = 1'b1; a_addr = 4'd2; a_data = 8'h66; step();
        clr_req = 1'b0; a_addr = 4'd4; a_data = 8'h55;
        n_tests++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_rise: got %b want 1", bus0.busy); end
        repeat (9) step();
        clr_req = 1'b1; step();
        clr_req = 1'b0;
        n_busy = (bus0.busy === 1'b1) ? 1 : 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus0.busy === 1'b1) n_busy++;
            else break;
        end
        n_tests++; if (n_busy != 16) begin n_fail++; $display("FAIL clr_restart_len: got %0d want 16", n_busy); end
        a_wren = 1'b0; step();
        n_tests++; if (bus0.a_q !== CLR) begin n_fail++; $display("FAIL busy_write_lost: got %h want a5", bus0.a_q); end
        a_addr = 4'd2; step();
        n_tests++; if (bus0.a_q !== CLR) begin n_fail++; $display("FAIL clr_overwrite: got %h want a5", bus0.a_q); end
    endtask

    initial begin
        test_reset();
`ifdef RAM_DP_CLR_SEQ_EN
        test_clear_sweep();
`else
        test_first_write();
`endif
        test_rdw();
        test_collision();
        test_out_reg();
        test_random();
`ifdef RAM_DP_CLR_SEQ_EN
        test_clear_req();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_dp_clr
